// File: rtl/wb_trace_fifo.sv
// Retire-trace capture FIFO: filters writeback debug traffic down to real register
// writes, buffers them in order and drains them over a valid/ready port.
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              debug_wb_pc,
  input  logic [3:0]               debug_wb_rf_we,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [31:0]              debug_wb_rf_wdata,
  input  logic                     trace_clr,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [4:0]               trace_wnum,
  output logic [31:0]              trace_wdata,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         commit_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 69;
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [EW-1:0]    mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             overflow_reg;
  logic [CNT_W-1:0] commit_cnt_reg;
  logic [CNT_W-1:0] drop_cnt_reg;

  logic [31:0]      byte_mask;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    head_entry;
  logic             push_req;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign byte_mask[gi*8 +: 8] = {8{debug_wb_rf_we[gi]}};
    end
  endgenerate

  assign push_req = (|debug_wb_rf_we) && (debug_wb_rf_wnum != 5'd0);
  assign wr_entry = {debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata & byte_mask};

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // Clear wins over everything; a full FIFO still accepts when the head leaves this cycle.
  assign pop  = !empty && trace_ready && !trace_clr;
  assign push = push_req && !trace_clr && (!full || pop);
  assign drop = push_req && !trace_clr && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (trace_clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_reg   <= 1'b0;
      commit_cnt_reg <= '0;
      drop_cnt_reg   <= '0;
    end else if (trace_clr) begin
      overflow_reg   <= 1'b0;
      commit_cnt_reg <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      if (push_req && (commit_cnt_reg != '1)) begin
        commit_cnt_reg <= commit_cnt_reg + CNT_ONE;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != '1) begin
          drop_cnt_reg <= drop_cnt_reg + CNT_ONE;
        end
      end
    end
  end

  // First-word-fall-through head; stale RAM contents are hidden while empty.
  assign head_entry  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign trace_valid = !empty;
  assign trace_pc    = head_entry[68:37];
  assign trace_wnum  = head_entry[36:32];
  assign trace_wdata = head_entry[31:0];
  assign fifo_count  = wr_ptr_reg - rd_ptr_reg;
  assign overflow    = overflow_reg;
  assign commit_cnt  = commit_cnt_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: a queue-based occupancy model predicts every
// accepted entry and status value; a negedge monitor compares the DUT against it.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [31:0]      debug_wb_pc = '0;
  logic [3:0]       debug_wb_rf_we = '0;
  logic [4:0]       debug_wb_rf_wnum = '0;
  logic [31:0]      debug_wb_rf_wdata = '0;
  logic             trace_clr = 1'b0;
  logic             trace_ready = 1'b0;
  logic             trace_valid;
  logic [31:0]      trace_pc;
  logic [4:0]       trace_wnum;
  logic [31:0]      trace_wdata;
  logic [4:0]       fifo_count;
  logic             overflow;
  logic [CNT_W-1:0] commit_cnt;
  logic [CNT_W-1:0] drop_cnt;

  int compared = 0;
  int mismatched = 0;

  wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .trace_clr(trace_clr), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_wnum(trace_wnum), .trace_wdata(trace_wdata),
    .fifo_count(fifo_count), .overflow(overflow),
    .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [68:0] sb[$];
  int          m_count = 0;
  bit          m_ovf = 1'b0;
  int          m_commit = 0;
  int          m_drop = 0;
  logic        m_req, m_pop, m_acc;
  logic [31:0] m_data;

  always_comb begin
    m_data = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (debug_wb_rf_we[b]) m_data[b*8 +: 8] = debug_wb_rf_wdata[b*8 +: 8];
    end
  end

  assign m_req = (debug_wb_rf_we != 4'h0) && (debug_wb_rf_wnum != 5'd0);
  assign m_pop = (m_count != 0) && trace_ready;
  assign m_acc = m_req && ((m_count < DEPTH) || m_pop);

  always @(posedge clk or negedge resetn) begin
    if (!resetn || trace_clr) begin
      m_count  <= 0;
      m_ovf    <= 1'b0;
      m_commit <= 0;
      m_drop   <= 0;
      sb.delete();
    end else begin
      m_count <= m_count - int'(m_pop) + int'(m_acc);
      if (m_req && m_commit < CMAX) m_commit <= m_commit + 1;
      if (m_req && !m_acc) begin
        m_ovf <= 1'b1;
        if (m_drop < CMAX) m_drop <= m_drop + 1;
      end
      if (m_acc) sb.push_back({debug_wb_pc, debug_wb_rf_wnum, m_data});
    end
  end

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    chk("fifo_count", 69'(fifo_count), 69'(m_count));
    chk("trace_valid", 69'(trace_valid), 69'(m_count != 0));
    chk("overflow", 69'(overflow), 69'(m_ovf));
    chk("commit_cnt", 69'(commit_cnt), 69'(m_commit));
    chk("drop_cnt", 69'(drop_cnt), 69'(m_drop));
    if (!trace_valid) begin
      chk("empty_data_zero", {trace_pc, trace_wnum, trace_wdata}, 69'h0);
    end else if (sb.size() == 0) begin
      chk("head_unexpected", {trace_pc, trace_wnum, trace_wdata}, 69'h0);
    end else begin
      chk("head_entry", {trace_pc, trace_wnum, trace_wdata}, sb[0]);
      if (trace_ready && !trace_clr && resetn) void'(sb.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wnum,
                       input logic [31:0] wdata, input logic rdy, input logic clr);
    debug_wb_pc       = pc;
    debug_wb_rf_we    = we;
    debug_wb_rf_wnum  = wnum;
    debug_wb_rf_wdata = wdata;
    trace_ready       = rdy;
    trace_clr         = clr;
    @(posedge clk);
    #1;
    $display("txn pc=%h we=%h wnum=%0d wdata=%h rdy=%0b clr=%0b -> valid=%0b cnt=%0d",
             pc, we, wnum, wdata, rdy, clr, trace_valid, fifo_count);
  endtask

  task automatic idle(input logic rdy);
    drive(32'h0, 4'h0, 5'd0, 32'h0, rdy, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 69'(trace_valid), 69'd0);
    chk("rst_count", 69'(fifo_count), 69'd0);
    resetn = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk("idle_count", 69'(fifo_count), 69'd0);
    chk("idle_commit", 69'(commit_cnt), 69'd0);

    // single push, then drain
    drive(32'h1c000000, 4'hf, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("single_valid", 69'(trace_valid), 69'd1);
    chk("single_pc", 69'(trace_pc), 69'h1c000000);
    chk("single_wnum", 69'(trace_wnum), 69'd5);
    chk("single_wdata", 69'(trace_wdata), 69'hDEADBEEF);
    chk("single_count", 69'(fifo_count), 69'd1);
    chk("single_commit", 69'(commit_cnt), 69'd1);
    idle(1'b1);
    chk("single_drained", 69'(trace_valid), 69'd0);

    // filter and byte mask
    drive(32'h200, 4'hf, 5'd0, 32'h11111111, 1'b0, 1'b0);
    chk("filter_r0_commit", 69'(commit_cnt), 69'd1);
    chk("filter_r0_valid", 69'(trace_valid), 69'd0);
    drive(32'h204, 4'h0, 5'd3, 32'h22222222, 1'b0, 1'b0);
    chk("filter_we0_count", 69'(fifo_count), 69'd0);
    drive(32'h208, 4'b0011, 5'd7, 32'h12345678, 1'b0, 1'b0);
    chk("mask_wdata", 69'(trace_wdata), 69'h00005678);
    idle(1'b1);

    // overflow with 17 pushes
    drive(32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1);
    chk("clr_commit", 69'(commit_cnt), 69'd0);
    for (int i = 0; i < 17; i++) begin
      drive(32'h100 + 32'(4 * i), 4'hf, 5'((i % 31) + 1), $urandom, 1'b0, 1'b0);
    end
    chk("ovf_count", 69'(fifo_count), 69'd16);
    chk("ovf_flag", 69'(overflow), 69'd1);
    chk("ovf_drop", 69'(drop_cnt), 69'd1);
    chk("ovf_commit", 69'(commit_cnt), 69'd17);
    drive(32'h300, 4'hf, 5'd9, 32'hCAFEF00D, 1'b1, 1'b0);
    chk("full_pushpop_count", 69'(fifo_count), 69'd16);
    chk("full_pushpop_drop", 69'(drop_cnt), 69'd1);
    repeat (17) idle(1'b1);
    chk("drain_count", 69'(fifo_count), 69'd0);

    // clear concurrent with a push at count 3
    for (int i = 0; i < 3; i++) drive(32'h400 + 32'(4 * i), 4'hf, 5'd2, $urandom, 1'b0, 1'b0);
    chk("pre_clr_count", 69'(fifo_count), 69'd3);
    drive(32'h40c, 4'hf, 5'd2, 32'h5, 1'b1, 1'b1);
    chk("clr_count", 69'(fifo_count), 69'd0);
    chk("clr_valid", 69'(trace_valid), 69'd0);
    chk("clr_commit2", 69'(commit_cnt), 69'd0);

    // async reset mid-drain
    for (int i = 0; i < 5; i++) drive(32'h500 + 32'(4 * i), 4'hf, 5'd4, $urandom, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 69'(trace_valid), 69'd0);
    chk("arst_count", 69'(fifo_count), 69'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(32'h600, 4'hf, 5'd6, 32'hA5A5A5A5, 1'b0, 1'b0);
    chk("post_arst_count", 69'(fifo_count), 69'd1);
    chk("post_arst_pc", 69'(trace_pc), 69'h600);
    idle(1'b1);

    // randomized traffic with alternating backpressure phases
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] we;
      logic       rdy;
      we  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      rdy = ((c / 300) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
      drive($urandom, we, 5'($urandom_range(0, 31)), $urandom, rdy,
            $urandom_range(0, 249) == 0);
    end
    repeat (DEPTH + 2) idle(1'b1);
    chk("sb_empty_end", 69'(sb.size()), 69'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
